// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS output gating block.
//   dds_state_e : gate FSM states (IDLE, LEAD, ACTIVE)
//   DDS_DATA_W  : default sample width
//   DDS_CNT_W   : default width of the start/stop delay counters
// ---------------------------------------------------------------------------
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEAD   = 2'd1,
    ACTIVE = 2'd2
  } dds_state_e;

  localparam int DDS_DATA_W = 12;
  localparam int DDS_CNT_W  = 4;

endpackage

// File: rtl/dds_delay_cnt.sv
// ---------------------------------------------------------------------------
// dds_delay_cnt
// Saturating up-counter with synchronous load, enable and terminal compare.
// Ports:
//   CLK      in   clock, rising edge
//   RESET_N  in   synchronous active-low reset (count -> 0)
//   clr      in   load clr_val this edge (priority over en)
//   clr_val  in   value loaded by clr
//   en       in   increment by one; holds at all-ones instead of wrapping
//   term     in   terminal value
//   hit      out  1 when the current count equals term
// ---------------------------------------------------------------------------
module dds_delay_cnt
  import dds_pkg::*;
#(
  parameter int CNT_W = DDS_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             clr,
  input  logic [CNT_W-1:0] clr_val,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= clr_val;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = (cnt_q == term);

endmodule

// File: rtl/dds_output_gate.sv
// ---------------------------------------------------------------------------
// dds_output_gate
// Output gating register between the LFM/DDS sample generator and the DAC
// pad. A capture window opens DELAY_START edges after an accepted start
// strobe and the last sample is taken DELAY_STOP edges after the first stop
// strobe; the window closes on the following edge. Outside the window the
// output is IDLE_VALUE (IDLE_MODE=0) or the last captured sample
// (IDLE_MODE=1), and OUTPUT_EN is low so the pad can be tri-stated.
//
// Strobe acceptance: SIGN_START_CALC is taken only on an edge where the gate
// is idle (READY=1 before the edge); otherwise it is dropped. The first
// SIGN_STOP_CALC while busy (or on the accepting start edge) arms the stop
// tracker; later stops are dropped until the window closes.
//
// Ports:
//   CLK              in   clock, rising edge
//   RESET_N          in   synchronous active-low reset / abort
//   INPUT            in   sample stream [DATA_W]
//   SIGN_START_CALC  in   start strobe (level per edge)
//   SIGN_STOP_CALC   in   stop strobe (level per edge)
//   READY            out  1 = idle, start will be accepted
//   OUTPUT           out  registered sample [DATA_W]
//   OUTPUT_EN        out  1 = OUTPUT holds a captured sample
//   DBG_STATE        out  current FSM state for observation
// ---------------------------------------------------------------------------
module dds_output_gate
  import dds_pkg::*;
#(
  parameter int               DATA_W      = DDS_DATA_W,
  parameter int               DELAY_START = 3,
  parameter int               DELAY_STOP  = 2,
  parameter int               CNT_W       = DDS_CNT_W,
  parameter int               IDLE_MODE   = 0,
  parameter logic [DATA_W-1:0] IDLE_VALUE = '0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] INPUT,
  input  logic              SIGN_START_CALC,
  input  logic              SIGN_STOP_CALC,
  output logic              READY,
  output logic [DATA_W-1:0] OUTPUT,
  output logic              OUTPUT_EN,
  output dds_state_e        DBG_STATE
);

  localparam logic [CNT_W-1:0] START_TERM = CNT_W'(DELAY_START);
  localparam logic [CNT_W-1:0] STOP_TERM  = CNT_W'(DELAY_STOP);

  dds_state_e        state_q, state_d;
  logic              ready_d, en_d;
  logic [DATA_W-1:0] out_d;
  logic              stop_seen_q, stop_seen_d;

  logic              start_clr, start_en, start_hit;
  logic [CNT_W-1:0]  start_clr_val;
  logic              stop_clr, stop_en, stop_hit;

  logic              start_acc, stop_acc, close_win;

  // Start counter: loaded with 1 on the accepting edge, so it equals
  // DELAY_START exactly on the edge of the first capture.
  dds_delay_cnt #(.CNT_W(CNT_W)) u_start_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (start_clr),
    .clr_val (start_clr_val),
    .en      (start_en),
    .term    (START_TERM),
    .hit     (start_hit)
  );

  // Stop counter: loaded with 0 on the stop edge; it reads DELAY_STOP on
  // the edge after the last capture, which is the closing edge.
  dds_delay_cnt #(.CNT_W(CNT_W)) u_stop_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (stop_clr),
    .clr_val ('0),
    .en      (stop_en),
    .term    (STOP_TERM),
    .hit     (stop_hit)
  );

  assign start_acc = (state_q == IDLE) && SIGN_START_CALC;
  assign close_win = (state_q != IDLE) && stop_seen_q && stop_hit;
  assign stop_acc  = SIGN_STOP_CALC && !stop_seen_q &&
                     ((state_q != IDLE) || start_acc);

  always_comb begin
    state_d       = state_q;
    ready_d       = READY;
    en_d          = OUTPUT_EN;
    out_d         = OUTPUT;
    stop_seen_d   = stop_seen_q;
    start_clr     = 1'b0;
    start_clr_val = '0;
    start_en      = 1'b0;
    stop_clr      = 1'b0;
    stop_en       = 1'b0;

    if (stop_acc) begin
      stop_seen_d = 1'b1;
      stop_clr    = 1'b1;
    end else if (stop_seen_q) begin
      stop_en = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d       = LEAD;
          ready_d       = 1'b0;
          start_clr     = 1'b1;
          start_clr_val = CNT_W'(1);
        end
      end
      LEAD: begin
        if (start_hit) begin
          state_d = ACTIVE;
          en_d    = 1'b1;
          out_d   = INPUT;
        end else begin
          start_en = 1'b1;
        end
      end
      ACTIVE: begin
        out_d = INPUT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Closing wins over everything else, including a LEAD->ACTIVE step on
    // the same edge (stop expiring during LEAD yields an empty window).
    if (close_win) begin
      state_d       = IDLE;
      ready_d       = 1'b1;
      en_d          = 1'b0;
      out_d         = (IDLE_MODE != 0) ? OUTPUT : IDLE_VALUE;
      stop_seen_d   = 1'b0;
      start_clr     = 1'b1;
      start_clr_val = '0;
      stop_clr      = 1'b1;
      stop_en       = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      READY       <= 1'b1;
      OUTPUT_EN   <= 1'b0;
      OUTPUT      <= IDLE_VALUE;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      READY       <= ready_d;
      OUTPUT_EN   <= en_d;
      OUTPUT      <= out_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_dds_output_gate.sv
// ---------------------------------------------------------------------------
// tb_dds_output_gate
// Three gate instances share clock, reset and sample stream:
//   u0 : 12-bit, DELAY_START=3, DELAY_STOP=2, IDLE_MODE=0, IDLE_VALUE=0x5A5
//   u1 : 16-bit, DELAY_START=3, DELAY_STOP=2, IDLE_MODE=1, IDLE_VALUE=0xBEEF
//   u2 : 12-bit, DELAY_START=3, DELAY_STOP=0, IDLE_MODE=0, IDLE_VALUE=0x3C3
// Edge numbers inside each scenario count from 1 at the first edge of that
// scenario. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_dds_output_gate;
  import dds_pkg::*;

  localparam logic [11:0] IV0 = 12'h5A5;
  localparam logic [15:0] IV1 = 16'hBEEF;
  localparam logic [11:0] IV2 = 12'h3C3;

  logic        CLK     = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] din     = '0;

  logic st0 = 1'b0, sp0 = 1'b0;
  logic st1 = 1'b0, sp1 = 1'b0;
  logic st2 = 1'b0, sp2 = 1'b0;

  logic        rdy0, en0, rdy1, en1, rdy2, en2;
  logic [11:0] out0, out2;
  logic [15:0] out1;
  dds_state_e  dbg0, dbg1, dbg2;

  int n_cmp = 0;
  int n_bad = 0;

  dds_output_gate #(
    .DATA_W(12), .DELAY_START(3), .DELAY_STOP(2), .CNT_W(4),
    .IDLE_MODE(0), .IDLE_VALUE(IV0)
  ) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .INPUT(din[11:0]),
    .SIGN_START_CALC(st0), .SIGN_STOP_CALC(sp0),
    .READY(rdy0), .OUTPUT(out0), .OUTPUT_EN(en0), .DBG_STATE(dbg0)
  );

  dds_output_gate #(
    .DATA_W(16), .DELAY_START(3), .DELAY_STOP(2), .CNT_W(4),
    .IDLE_MODE(1), .IDLE_VALUE(IV1)
  ) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .INPUT(din),
    .SIGN_START_CALC(st1), .SIGN_STOP_CALC(sp1),
    .READY(rdy1), .OUTPUT(out1), .OUTPUT_EN(en1), .DBG_STATE(dbg1)
  );

  dds_output_gate #(
    .DATA_W(12), .DELAY_START(3), .DELAY_STOP(0), .CNT_W(4),
    .IDLE_MODE(0), .IDLE_VALUE(IV2)
  ) u2 (
    .CLK(CLK), .RESET_N(RESET_N), .INPUT(din[11:0]),
    .SIGN_START_CALC(st2), .SIGN_STOP_CALC(sp2),
    .READY(rdy2), .OUTPUT(out2), .OUTPUT_EN(en2), .DBG_STATE(dbg2)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    RESET_N = 1'b0;
    step();
    step();
    if (rdy0 !== 1'b1) begin $display("FAIL reset_rdy0: got %b want 1", rdy0); n_bad++; end
    n_cmp++;
    if (en0 !== 1'b0) begin $display("FAIL reset_en0: got %b want 0", en0); n_bad++; end
    n_cmp++;
    if (out0 !== IV0) begin $display("FAIL reset_out0: got %h want %h", out0, IV0); n_bad++; end
    n_cmp++;
    if (rdy1 !== 1'b1) begin $display("FAIL reset_rdy1: got %b want 1", rdy1); n_bad++; end
    n_cmp++;
    if (en1 !== 1'b0) begin $display("FAIL reset_en1: got %b want 0", en1); n_bad++; end
    n_cmp++;
    if (out1 !== IV1) begin $display("FAIL reset_out1: got %h want %h", out1, IV1); n_bad++; end
    n_cmp++;
    if (out2 !== IV2) begin $display("FAIL reset_out2: got %h want %h", out2, IV2); n_bad++; end
    n_cmp++;
    if (dbg2 !== IDLE) begin $display("FAIL reset_state2: got %0d want %0d", dbg2, IDLE); n_bad++; end
    n_cmp++;
    RESET_N = 1'b1;
    step();
  endtask

  // Mode-0 window on u0 (sel=0) or u2 (sel=2): start at k, stop at m,
  // optional extra starts xs1/xs2 and extra stop xp (0 = none), n edges.
  // Expected: captures on k+DS..m+DSTOP, READY low on k..m+DSTOP.
  task automatic run_win(input string name, input int sel, input int k,
                         input int m, input int xs1, input int xs2,
                         input int xp, input int n);
    int          ds, dsp;
    logic [11:0] iv, cur, exp_out, obs_out;
    logic        win, busy, obs_rdy, obs_en;
    dds_state_e  exp_st, obs_st;
    ds  = 3;
    dsp = (sel == 2) ? 0 : 2;
    iv  = (sel == 2) ? IV2 : IV0;
    for (int e = 1; e <= n; e++) begin
      din = 16'(e * 291 + k * 17 + 16'h0400);
      cur = din[11:0];
      if (sel == 2) begin
        st2 = (e == k) || (e == xs1) || (e == xs2);
        sp2 = (e == m) || (e == xp);
      end else begin
        st0 = (e == k) || (e == xs1) || (e == xs2);
        sp0 = (e == m) || (e == xp);
      end
      step();
      st0 = 1'b0; sp0 = 1'b0; st2 = 1'b0; sp2 = 1'b0;
      win     = (e >= k + ds) && (e <= m + dsp);
      busy    = (e >= k) && (e <= m + dsp);
      exp_out = win ? cur : iv;
      exp_st  = !busy ? IDLE : ((e >= k + ds) ? ACTIVE : LEAD);
      obs_out = (sel == 2) ? out2 : out0;
      obs_rdy = (sel == 2) ? rdy2 : rdy0;
      obs_en  = (sel == 2) ? en2 : en0;
      obs_st  = (sel == 2) ? dbg2 : dbg0;
      if (obs_rdy !== !busy) begin
        $display("FAIL %s ready @%0d: got %b want %b", name, e, obs_rdy, !busy); n_bad++;
      end
      n_cmp++;
      if (obs_en !== win) begin
        $display("FAIL %s output_en @%0d: got %b want %b", name, e, obs_en, win); n_bad++;
      end
      n_cmp++;
      if (obs_out !== exp_out) begin
        $display("FAIL %s output @%0d: got %h want %h", name, e, obs_out, exp_out); n_bad++;
      end
      n_cmp++;
      if (obs_st !== exp_st) begin
        $display("FAIL %s state @%0d: got %0d want %0d", name, e, obs_st, exp_st); n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_window;
    run_win("basic", 0, 10, 20, 0, 0, 0, 26);
  endtask

  task automatic test_same_edge;
    run_win("same_edge", 0, 5, 5, 0, 0, 0, 10);
  endtask

  task automatic test_back_to_back;
    // Start at 15 (ACTIVE) and 23 (closing edge) and stop at 21 are dropped.
    run_win("dup", 0, 10, 20, 15, 23, 21, 23);
    // First edge here is edge 24 of the previous scenario: start accepted.
    run_win("restart", 0, 1, 3, 0, 0, 0, 8);
  endtask

  task automatic test_reset_mid;
    for (int e = 1; e <= 15; e++) begin
      din = 16'(e * 77 + 16'h0100);
      st0 = (e == 10);
      step();
      st0 = 1'b0;
    end
    if (en0 !== 1'b1) begin $display("FAIL mid_pre_en: got %b want 1", en0); n_bad++; end
    n_cmp++;
    if (out0 !== din[11:0]) begin $display("FAIL mid_pre_out: got %h want %h", out0, din[11:0]); n_bad++; end
    n_cmp++;
    RESET_N = 1'b0;
    step();
    if (en0 !== 1'b0) begin $display("FAIL mid_rst_en: got %b want 0", en0); n_bad++; end
    n_cmp++;
    if (rdy0 !== 1'b1) begin $display("FAIL mid_rst_rdy: got %b want 1", rdy0); n_bad++; end
    n_cmp++;
    if (out0 !== IV0) begin $display("FAIL mid_rst_out: got %h want %h", out0, IV0); n_bad++; end
    n_cmp++;
    if (dbg0 !== IDLE) begin $display("FAIL mid_rst_state: got %0d want %0d", dbg0, IDLE); n_bad++; end
    n_cmp++;
    RESET_N = 1'b1;
    step();
    // Edge 18: same pattern as the basic window, shifted.
    run_win("after_rst", 0, 1, 11, 0, 0, 0, 16);
  endtask

  task automatic test_hold_mode;
    logic [15:0] exp_out;
    logic        exp_en, exp_rdy;
    for (int e = 1; e <= 10; e++) begin
      din = (e == 6) ? 16'h1234 : 16'(16'hA000 + e);
      st1 = (e == 2);
      sp1 = (e == 4);
      step();
      st1 = 1'b0; sp1 = 1'b0;
      exp_en  = (e >= 5) && (e <= 6);
      exp_rdy = !((e >= 2) && (e <= 6));
      exp_out = (e < 5) ? IV1 : (exp_en ? din : 16'h1234);
      if (en1 !== exp_en) begin
        $display("FAIL hold output_en @%0d: got %b want %b", e, en1, exp_en); n_bad++;
      end
      n_cmp++;
      if (rdy1 !== exp_rdy) begin
        $display("FAIL hold ready @%0d: got %b want %b", e, rdy1, exp_rdy); n_bad++;
      end
      n_cmp++;
      if (out1 !== exp_out) begin
        $display("FAIL hold output @%0d: got %h want %h", e, out1, exp_out); n_bad++;
      end
      n_cmp++;
    end
    // Reset forces IDLE_VALUE even in hold mode.
    RESET_N = 1'b0;
    step();
    if (out1 !== IV1) begin $display("FAIL hold_rst_out: got %h want %h", out1, IV1); n_bad++; end
    n_cmp++;
    RESET_N = 1'b1;
    step();
  endtask

  task automatic test_zero_stop;
    run_win("dstop0", 2, 10, 20, 0, 0, 0, 24);
    // 43 edges without a stop before it arrives: must stay ACTIVE throughout.
    run_win("long", 2, 1, 44, 0, 0, 0, 48);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    test_reset();
    test_window();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    test_hold_mode();
    test_zero_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_output_gate.md
# dds_output_gate

Parametrised output gating register for the LFM/DDS chain. It sits between the sample generator and the DAC pad. It opens a capture window a fixed number of clocks after the start strobe and closes it a fixed number of clocks after the stop strobe. Outside the window it drives a defined idle level and an output-enable for pad tri-stating. It adds configurable width and delays, an idle mode, a valid/enable flag, synchronous abort via reset, and fully defined overlap behaviour.

## Interface
- DATA_W, 12, sample width
- DELAY_START, 3, clocks from accepted start to first captured sample; legal range 1..2^CNT_W-1
- DELAY_STOP, 2, clocks from accepted stop to last captured sample; legal range 0..2^CNT_W-1
- CNT_W, 4, width of both delay counters
- IDLE_MODE, 0, selects the OUTPUT level outside the window: 0 = drive IDLE_VALUE, 1 = hold the last captured sample
- IDLE_VALUE, 0, DATA_W-bit idle level used when IDLE_MODE=0
- CLK  in  1  single clock, all logic on rising edge
- RESET_N  in  1  synchronous, active-low reset
- INPUT  in  DATA_W  sample stream from the generator
- SIGN_START_CALC  in  1  start strobe, level sampled per edge
- SIGN_STOP_CALC  in  1  stop strobe, level sampled per edge
- READY  out  1  1 = idle and able to accept a start
- OUTPUT  out  DATA_W  registered sample
- OUTPUT_EN  out  1  1 = OUTPUT carries a captured sample; the top level uses it to tri-state the pad

## Operation
- States: IDLE, LEAD, ACTIVE. A separate stop tracker (stop_seen, stop_cnt) runs in LEAD and ACTIVE.
- IDLE: READY=1, OUTPUT_EN=0. If SIGN_START_CALC=1 at edge k:
  - go to LEAD
  - start_cnt=1, READY=0
- LEAD: at each edge, if start_cnt==DELAY_START:
  - go to ACTIVE
  - OUTPUT<=INPUT, OUTPUT_EN<=1
  - otherwise start_cnt++
  - The first capture therefore happens at edge k+DELAY_START.
- ACTIVE: OUTPUT<=INPUT on every edge until the window closes.
- Stop tracker:
  - In LEAD or ACTIVE, the first SIGN_STOP_CALC=1 at edge m sets stop_seen and stop_cnt=0.
  - While stop_seen, stop_cnt increments by 1 per edge.
  - Further stop strobes are ignored.
  - Stop in IDLE is ignored unless start is accepted on the same edge; then m=k.
- Close at edge e=m+DELAY_STOP+1, in any state:
  - go to IDLE
  - READY<=1, OUTPUT_EN<=0
  - OUTPUT<=IDLE_VALUE (mode 0) or unchanged (mode 1)
  - counters and stop_seen cleared
- Captures occur on edges max(k+DELAY_START, k) .. m+DELAY_STOP. If this range is empty because stop expires during LEAD, no sample is ever captured and OUTPUT_EN stays 0.
- A start while READY=0 is ignored, including at edge e itself. The earliest restart is edge e+1.
- Stop never arrives: ACTIVE persists indefinitely. Counters saturate and do not wrap.
- RESET_N=0 at any edge, including mid-window:
  - IDLE
  - READY=1, OUTPUT_EN=0, OUTPUT=IDLE_VALUE (both modes)
  - all counters and flags 0
- The power-up state is undefined until the first reset.

## Timing
- All outputs registered, no combinational path from inputs to outputs.
- Reset values: READY=1, OUTPUT_EN=0, OUTPUT=IDLE_VALUE.
- Start-to-first-sample latency is DELAY_START edges. Stop-to-last-sample latency is DELAY_STOP edges. The window closes 1 edge after the last sample.
- OUTPUT at edge n equals INPUT sampled at edge n (1-cycle register).

## Structure
- Shared package dds_pkg holds:
  - state enum (IDLE, LEAD, ACTIVE)
  - default DATA_W=12 and CNT_W=4 constants
- One sub-module, dds_delay_cnt: saturating CNT_W-bit counter with clear, enable and terminal-compare. It is instantiated twice, once for start and once for stop.

## Test plan
- Reset then start at edge 10, DELAY_START=3, DELAY_STOP=2, stop at edge 20 -> READY falls at 10; OUTPUT_EN=1 and OUTPUT==INPUT on edges 13..22; idle at 23 with OUTPUT=IDLE_VALUE and READY=1.
- Start and stop on the same edge 5 (3/2) -> capture edges empty (8 > 7), OUTPUT_EN never 1, READY=1 at edge 8.
- Second start during ACTIVE and second stop during the stop count -> both ignored, timing identical to scenario 1. A start at edge 23 is ignored; a start at edge 24 is accepted.
- RESET_N=0 at edge 16 mid-window -> OUTPUT_EN=0, READY=1, OUTPUT=IDLE_VALUE at 16; a start at 18 behaves exactly like scenario 1 shifted.
- IDLE_MODE=1, DATA_W=16, last sample 0x1234 -> after close OUTPUT stays 0x1234 and OUTPUT_EN=0.
- DELAY_STOP=0, stop at edge 20 -> last capture at 20, idle at 21. A window with no stop for 40 edges -> stays ACTIVE with no counter wrap.
